// File: rtl/amba3_axi_rd_arbiter_pkg.sv
// Shared AR-channel field layout and enums for the 2:1 AXI3 read arbiter.
// Combinational content only: no latency and no backpressure.
// The AR control word sits in the 18 LSBs of every AR payload, below the address.
package amba3_axi_rd_arbiter_pkg;

  localparam int AMBA3_AXI_AR_CTRL_BITS = 18;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_type_t;

  typedef enum logic [1:0] {
    LOCK_NORMAL    = 2'b00,
    LOCK_EXCLUSIVE = 2'b01,
    LOCK_LOCKED    = 2'b10,
    LOCK_RSVD      = 2'b11
  } lock_type_t;

  typedef logic [3:0] cache_attr_t;
  typedef logic [2:0] prot_attr_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_type_t;

  // Field order fixes the payload layout: {addr, len, size, burst, lock, cache, prot}
  typedef struct packed {
    logic [3:0]  len;
    logic [2:0]  size;
    burst_type_t burst;
    lock_type_t  lock;
    cache_attr_t cache;
    prot_attr_t  prot;
  } ar_ctrl_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/amba3_axi_rd_arbiter_rr_arb2.sv
// 2-way round-robin grant; a tie goes to the master that did not win last.
// Grant is combinational from i_req; the pointer moves only on i_accept.
// Backpressure: a request that is not accepted leaves the pointer where it was.
module amba3_axi_rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_grant,
  output logic       o_grant_idx,
  output logic       o_any
);

  logic r_last_grant;
  logic w_idx;

  always_comb begin
    w_idx = 1'b0;
    if (i_req == 2'b11) w_idx = ~r_last_grant;
    else if (i_req[1])  w_idx = 1'b1;
  end

  assign o_any       = |i_req;
  assign o_grant_idx = w_idx;
  assign o_grant     = {w_idx, ~w_idx} & {2{o_any}};

  // Resetting to 1 lets master 0 win the first tie.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                r_last_grant <= 1'b1;
    else if (i_accept && o_any)  r_last_grant <= w_idx;
  end

endmodule

// File: rtl/amba3_axi_rd_arbiter.sv
// 2:1 AXI3 read arbiter: round-robin AR with a master-select ID MSB, R routed back by that bit.
// Latency: AR 1 cycle into the m_* registers (at most 1 AR per 2 cycles); R path is combinational.
// Backpressure: AR held in m_* while !m_arready; R ready follows the selected master. Macro: AMBA3_AXI_RD_ARB_LOCK_EN.
module amba3_axi_rd_arbiter
  import amba3_axi_rd_arbiter_pkg::*;
#(
  parameter int TXID_SIZE       = 4,
  parameter int ADDR_SIZE       = 32,
  parameter int DATA_SIZE       = 32,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                                              aclk,
  input  logic                                              areset_n,
  input  logic [1:0]                                        s_arvalid,
  output logic [1:0]                                        s_arready,
  input  logic [2*TXID_SIZE-1:0]                            s_arid,
  input  logic [2*(ADDR_SIZE+AMBA3_AXI_AR_CTRL_BITS)-1:0]   s_ar,
  output logic [1:0]                                        s_rvalid,
  input  logic [1:0]                                        s_rready,
  output logic [TXID_SIZE-1:0]                              s_rid,
  output logic [DATA_SIZE+2:0]                              s_r,
  output logic                                              m_arvalid,
  input  logic                                              m_arready,
  output logic [TXID_SIZE:0]                                m_arid,
  output logic [ADDR_SIZE+AMBA3_AXI_AR_CTRL_BITS-1:0]       m_ar,
  input  logic                                              m_rvalid,
  output logic                                              m_rready,
  input  logic [TXID_SIZE:0]                                m_rid,
  input  logic [DATA_SIZE+2:0]                              m_r
);

  localparam int AR_W  = ADDR_SIZE + AMBA3_AXI_AR_CTRL_BITS;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  arb_state_t           r_state;
  logic [CNT_W-1:0]     r_cnt [2];
  logic [1:0]           w_eligible;
  logic [1:0]           w_req;
  logic [1:0]           w_grant;
  logic [1:0]           w_lock_ok;
  logic [1:0]           w_inc;
  logic [1:0]           w_dec;
  logic                 w_grant_idx;
  logic                 w_take;
  logic                 w_sel;
  logic                 w_r_done;
  logic [AR_W-1:0]      w_ar_pick;
  logic [TXID_SIZE-1:0] w_id_pick;

  always_comb begin
    w_eligible = 2'b00;
    for (int i = 0; i < 2; i++)
      w_eligible[i] = s_arvalid[i] && (r_cnt[i] < CNT_MAX) && w_lock_ok[i];
  end

  // Masking requests outside IDLE (and in reset) keeps s_arready low in those windows.
  assign w_req = (areset_n && r_state == ARB_IDLE) ? w_eligible : 2'b00;

  amba3_axi_rr_arb2 u_rr_arb (
    .i_clk       (aclk),
    .i_rst_n     (areset_n),
    .i_req       (w_req),
    .i_accept    (w_take),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_any       (w_take)
  );

  assign s_arready = w_grant;
  assign w_ar_pick = w_grant_idx ? s_ar[AR_W +: AR_W] : s_ar[0 +: AR_W];
  assign w_id_pick = w_grant_idx ? s_arid[TXID_SIZE +: TXID_SIZE] : s_arid[0 +: TXID_SIZE];

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_state   <= ARB_IDLE;
      m_arvalid <= 1'b0;
      m_arid    <= '0;
      m_ar      <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_take) begin
            m_arvalid <= 1'b1;
            m_arid    <= {w_grant_idx, w_id_pick};
            m_ar      <= w_ar_pick;
            r_state   <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (m_arvalid && m_arready) begin
            m_arvalid <= 1'b0;
            r_state   <= ARB_IDLE;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign w_sel    = m_rid[TXID_SIZE];
  assign s_rvalid = w_sel ? {m_rvalid, 1'b0} : {1'b0, m_rvalid};
  assign m_rready = s_rready[w_sel];
  assign s_rid    = m_rid[TXID_SIZE-1:0];
  assign s_r      = m_r;
  assign w_r_done = m_rvalid && m_rready && m_r[0];

  assign w_inc = w_take   ? (w_grant_idx ? 2'b10 : 2'b01) : 2'b00;
  assign w_dec = w_r_done ? (w_sel       ? 2'b10 : 2'b01) : 2'b00;

  // A grant and a completing burst for the same master cancel out.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_cnt[0] <= '0;
      r_cnt[1] <= '0;
    end else begin
      if (w_r_done && r_cnt[w_sel] == '0)
        $error("R last for master %0d with no outstanding burst", w_sel);
      for (int i = 0; i < 2; i++) begin
        if (w_inc[i] && !w_dec[i])
          r_cnt[i] <= r_cnt[i] + 1'b1;
        else if (w_dec[i] && !w_inc[i] && r_cnt[i] != '0)
          r_cnt[i] <= r_cnt[i] - 1'b1;
      end
    end
  end

`ifdef AMBA3_AXI_RD_ARB_LOCK_EN
  logic     r_lock_active;
  logic     r_lock_owner;
  ar_ctrl_t w_ctrl_pick;

  assign w_ctrl_pick = ar_ctrl_t'(w_ar_pick[AMBA3_AXI_AR_CTRL_BITS-1:0]);
  assign w_lock_ok   = !r_lock_active ? 2'b11 : (r_lock_owner ? 2'b10 : 2'b01);

  // A locked sequence ends with the owner's first granted AR that is not LOCKED.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_lock_active <= 1'b0;
      r_lock_owner  <= 1'b0;
    end else if (w_take) begin
      if (w_ctrl_pick.lock == LOCK_LOCKED) begin
        r_lock_active <= 1'b1;
        r_lock_owner  <= w_grant_idx;
      end else if (w_grant_idx == r_lock_owner) begin
        r_lock_active <= 1'b0;
      end
    end
  end
`else
  assign w_lock_ok = 2'b11;
`endif

endmodule

// File: tb/tb_amba3_axi_rd_arbiter.sv
// Directed stimulus for the 2:1 AXI3 read arbiter with MAX_OUTSTANDING=2.
// Expected AR and R handshakes are queued by stimulus and popped by a negedge monitor.
module tb_amba3_axi_rd_arbiter;
  import amba3_axi_rd_arbiter_pkg::*;

  localparam int TX   = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXO = 2;
  localparam int ARW  = AW + AMBA3_AXI_AR_CTRL_BITS;

  logic            aclk = 1'b0;
  logic            areset_n;
  logic [1:0]      s_arvalid, s_arready, s_rvalid, s_rready;
  logic [2*TX-1:0] s_arid;
  logic [2*ARW-1:0] s_ar;
  logic [TX-1:0]   s_rid;
  logic [DW+2:0]   s_r;
  logic            m_arvalid, m_arready, m_rvalid, m_rready;
  logic [TX:0]     m_arid, m_rid;
  logic [ARW-1:0]  m_ar;
  logic [DW+2:0]   m_r;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed { logic [TX:0] id; logic [ARW-1:0] ar; } ar_exp_t;
  typedef struct packed { logic [1:0] vld; logic [TX-1:0] id; logic [DW+2:0] r; } r_exp_t;
  ar_exp_t ar_q[$];
  r_exp_t  r_q[$];
  ar_exp_t ea;
  r_exp_t  er;

  logic [ARW-1:0] ar1, ar_s0, ar_s1;
  logic [DW+2:0]  rb;
  logic [1:0]     exp_rdy [11];
  logic           exp_vld [11];

  always #5 aclk = ~aclk;

  amba3_axi_rd_arbiter #(
    .TXID_SIZE(TX), .ADDR_SIZE(AW), .DATA_SIZE(DW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .aclk(aclk), .areset_n(areset_n),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_ar(s_ar),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_r(s_r),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_ar(m_ar),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_r(m_r)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [ARW-1:0] mk_ar(input logic [AW-1:0] addr, input logic [3:0] len);
    ar_ctrl_t c;
    c.len   = len;
    c.size  = 3'd2;
    c.burst = BURST_INCR;
    c.lock  = LOCK_NORMAL;
    c.cache = 4'h3;
    c.prot  = 3'd0;
    return {addr, c};
  endfunction

  always @(negedge aclk) begin
    if (areset_n && m_arvalid && m_arready) begin
      if (ar_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL ar_unexpected: got id 0x%0h, want no AR", m_arid);
      end else begin
        ea = ar_q.pop_front();
        chk("ar_id", 64'(m_arid), 64'(ea.id));
        chk("ar_payload", 64'(m_ar), 64'(ea.ar));
      end
    end
    if (areset_n && m_rvalid && m_rready) begin
      if (r_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL r_unexpected: got rid 0x%0h, want no R", m_rid);
      end else begin
        er = r_q.pop_front();
        chk("r_valid_route", 64'(s_rvalid), 64'(er.vld));
        chk("r_id", 64'(s_rid), 64'(er.id));
        chk("r_payload", 64'(s_r), 64'(er.r));
      end
    end
  end

  initial begin
    areset_n = 1'b0; s_arvalid = 2'b11; s_arid = '0; s_ar = '0; s_rready = 2'b00;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rid = '0; m_r = '0;
    ar1   = 50'h100_3_2_1_0_3_0;
    ar1   = mk_ar(32'h100, 4'h3);
    ar_s0 = mk_ar(32'h2000, 4'h1);
    ar_s1 = mk_ar(32'h3000, 4'h7);

    // Reset values, with both masters requesting
    repeat (2) @(negedge aclk);
    chk("rst_m_arvalid", 64'(m_arvalid), 64'd0);
    chk("rst_m_arid", 64'(m_arid), 64'd0);
    chk("rst_m_ar", 64'(m_ar), 64'd0);
    chk("rst_s_arready", 64'(s_arready), 64'd0);
    tick();
    areset_n = 1'b1; s_arvalid = 2'b00;

    // Single AR from s0: id 3, addr 0x100, len 3
    tick();
    s_arvalid = 2'b01; s_arid = 8'h03; s_ar = {{ARW{1'b0}}, ar1}; m_arready = 1'b1;
    ar_q.push_back('{id: 5'h03, ar: ar1});
    @(negedge aclk);
    chk("t1_s_arready", 64'(s_arready), 64'h1);
    chk("t1_latency_m_arvalid", 64'(m_arvalid), 64'd0);
    tick();
    s_arvalid = 2'b00;
    @(negedge aclk);
    chk("t1_s_arready_one_cycle", 64'(s_arready), 64'h0);
    chk("t1_m_arvalid", 64'(m_arvalid), 64'd1);
    chk("t1_m_arid", 64'(m_arid), 64'h03);
    chk("t1_cnt0", 64'(dut.r_cnt[0]), 64'd1);
    tick();
    m_arready = 1'b0;
    @(negedge aclk);
    chk("t1_m_arvalid_drop", 64'(m_arvalid), 64'd0);

    // Last beat back to s0 releases its counter
    tick();
    rb = {32'hCAFE0001, 2'b00, 1'b1};
    m_rvalid = 1'b1; m_rid = 5'h03; m_r = rb; s_rready = 2'b01;
    r_q.push_back('{vld: 2'b01, id: 4'h3, r: rb});
    tick();
    m_rvalid = 1'b0; s_rready = 2'b00;
    @(negedge aclk);
    chk("t1_cnt0_release", 64'(dut.r_cnt[0]), 64'd0);

    // R to s1 (rid 0x15) stalls while only s0 is ready
    tick();
    rb = {32'h12345678, 2'b00, 1'b0};
    m_rvalid = 1'b1; m_rid = 5'h15; m_r = rb; s_rready = 2'b01;
    @(negedge aclk);
    chk("t4_s_rvalid", 64'(s_rvalid), 64'h2);
    chk("t4_m_rready_stall", 64'(m_rready), 64'd0);
    chk("t4_s_rid", 64'(s_rid), 64'h5);
    tick();
    s_rready = 2'b10;
    r_q.push_back('{vld: 2'b10, id: 4'h5, r: rb});
    @(negedge aclk);
    chk("t4_m_rready", 64'(m_rready), 64'd1);
    tick();
    m_rvalid = 1'b0; s_rready = 2'b00;

    // Both masters request continuously; s0 won last, so order is 1,0,1,0 then both at the limit
    exp_rdy = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    exp_vld = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tick();
    s_arvalid = 2'b11; s_arid = {4'hA, 4'h5}; s_ar = {ar_s1, ar_s0}; m_arready = 1'b1;
    ar_q.push_back('{id: 5'h1A, ar: ar_s1});
    ar_q.push_back('{id: 5'h05, ar: ar_s0});
    ar_q.push_back('{id: 5'h1A, ar: ar_s1});
    ar_q.push_back('{id: 5'h05, ar: ar_s0});
    for (int k = 0; k < 11; k++) begin
      @(negedge aclk);
      chk($sformatf("t2_s_arready_%0d", k), 64'(s_arready), 64'(exp_rdy[k]));
      chk($sformatf("t2_m_arvalid_%0d", k), 64'(m_arvalid), 64'(exp_vld[k]));
    end
    chk("t2_cnt0", 64'(dut.r_cnt[0]), 64'd2);
    chk("t2_cnt1", 64'(dut.r_cnt[1]), 64'd2);

    // s0 blocked at the limit until an rlast with rid MSB=0 arrives
    tick();
    rb = {32'hBEEF0002, 2'b00, 1'b1};
    m_rvalid = 1'b1; m_rid = 5'h05; m_r = rb; s_rready = 2'b01;
    r_q.push_back('{vld: 2'b01, id: 4'h5, r: rb});
    ar_q.push_back('{id: 5'h05, ar: ar_s0});
    @(negedge aclk);
    chk("t3_held", 64'(s_arready), 64'h0);
    tick();
    m_rvalid = 1'b0; s_rready = 2'b00;
    @(negedge aclk);
    chk("t3_released", 64'(s_arready), 64'h1);
    tick();
    s_arvalid = 2'b10;
    @(negedge aclk);
    chk("t3_m_arvalid", 64'(m_arvalid), 64'd1);
    tick();
    @(negedge aclk);
    chk("t3_cnt0", 64'(dut.r_cnt[0]), 64'd2);

    // Free s1, then hold its AR with m_arready low
    tick();
    rb = {32'hD00D0003, 2'b10, 1'b1};
    m_rvalid = 1'b1; m_rid = 5'h1A; m_r = rb; s_rready = 2'b10; m_arready = 1'b0;
    r_q.push_back('{vld: 2'b10, id: 4'hA, r: rb});
    tick();
    m_rvalid = 1'b0; s_rready = 2'b00;
    ar_q.push_back('{id: 5'h1A, ar: ar_s1});
    @(negedge aclk);
    chk("t5_grant_s1", 64'(s_arready), 64'h2);
    tick();
    s_arvalid = 2'b11;
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk);
      chk($sformatf("t5_hold_vld_%0d", k), 64'(m_arvalid), 64'd1);
      chk($sformatf("t5_hold_id_%0d", k), 64'(m_arid), 64'h1A);
      chk($sformatf("t5_hold_ar_%0d", k), 64'(m_ar), 64'(ar_s1));
      chk($sformatf("t5_hold_rdy_%0d", k), 64'(s_arready), 64'h0);
    end
    tick();
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    @(negedge aclk);
    chk("t5_m_arvalid_drop", 64'(m_arvalid), 64'd0);

    // Reset while an s0 AR is held in BUSY
    tick();
    rb = {32'h0000F00D, 2'b00, 1'b1};
    m_rvalid = 1'b1; m_rid = 5'h05; m_r = rb; s_rready = 2'b01;
    r_q.push_back('{vld: 2'b01, id: 4'h5, r: rb});
    tick();
    m_rvalid = 1'b0; s_rready = 2'b00;
    tick();
    @(negedge aclk);
    chk("t6_busy_m_arvalid", 64'(m_arvalid), 64'd1);
    chk("t6_cnt0_before", 64'(dut.r_cnt[0]), 64'd2);
    #1 areset_n = 1'b0;
    #1;
    chk("t6_rst_m_arvalid", 64'(m_arvalid), 64'd0);
    chk("t6_rst_m_arid", 64'(m_arid), 64'd0);
    chk("t6_rst_cnt0", 64'(dut.r_cnt[0]), 64'd0);
    chk("t6_rst_cnt1", 64'(dut.r_cnt[1]), 64'd0);
    chk("t6_rst_s_arready", 64'(s_arready), 64'h0);
    tick();
    areset_n = 1'b1; m_arready = 1'b1;
    ar_q.push_back('{id: 5'h05, ar: ar_s0});
    @(negedge aclk);
    chk("t6_first_tie_s0", 64'(s_arready), 64'h1);
    tick();
    s_arvalid = 2'b00;
    tick();
    m_arready = 1'b0;

    repeat (3) @(negedge aclk);
    chk("ar_queue_drained", 64'(ar_q.size()), 64'd0);
    chk("r_queue_drained", 64'(r_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
